// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM and the datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite;
  logic       pcWriteCond;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       memToReg;
  logic       regDst;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] opAlu;
  logic [1:0] pcSource;
  logic       instrDone;
  logic       illegalOp;
  logic [3:0] state;

  modport master (
    input  opcode, memReady,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite,
    output irWrite, memToReg, regDst, regWrite, aluSrcA,
    output aluSrcB, opAlu, pcSource, instrDone, illegalOp,
    output state
  );

  modport slave (
    output opcode, memReady,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite,
    input  irWrite, memToReg, regDst, regWrite, aluSrcA,
    input  aluSrcB, opAlu, pcSource, instrDone, illegalOp,
    input  state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore outputs from state; FETCH enables gated by memReady.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RCOMP   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ILLEGAL = 4'd10
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.iorD        = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.memToReg    = 1'b0;
    bus.regDst      = 1'b0;
    bus.regWrite    = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = 2'b00;
    bus.opAlu       = 2'b00;
    bus.pcSource    = 2'b00;
    bus.instrDone   = 1'b0;
    bus.illegalOp   = 1'b0;
    bus.state       = state_q;
    case (state_q)
      S_FETCH: begin
        bus.memRead = 1'b1;
        bus.aluSrcB = 2'b01;
        bus.irWrite = bus.memReady;
        bus.pcWrite = bus.memReady;
        if (bus.memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.aluSrcB = 2'b11;
        unique case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.memRead = 1'b1;
        bus.iorD    = 1'b1;
        if (bus.memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.regWrite  = 1'b1;
        bus.memToReg  = 1'b1;
        bus.instrDone = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        bus.memWrite  = 1'b1;
        bus.iorD      = 1'b1;
        bus.instrDone = bus.memReady;
        if (bus.memReady) state_d = S_FETCH;
      end
      S_EXEC: begin
        bus.aluSrcA = 1'b1;
        bus.opAlu   = 2'b10;
        state_d = S_RCOMP;
      end
      S_RCOMP: begin
        bus.regWrite  = 1'b1;
        bus.regDst    = 1'b1;
        bus.instrDone = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.opAlu       = 2'b01;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = 2'b01;
        bus.instrDone   = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        bus.pcWrite   = 1'b1;
        bus.pcSource  = 2'b10;
        bus.instrDone = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        bus.illegalOp = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // No request may leave the block while reset is held
    if (!rst_n) begin
      bus.pcWrite     = 1'b0;
      bus.iorD        = 1'b0;
      bus.memRead     = 1'b0;
      bus.irWrite     = 1'b0;
      bus.aluSrcB     = 2'b00;
      bus.pcWriteCond = 1'b0;
      bus.memWrite    = 1'b0;
      bus.memToReg    = 1'b0;
      bus.regDst      = 1'b0;
      bus.regWrite    = 1'b0;
      bus.aluSrcA     = 1'b0;
      bus.opAlu       = 2'b00;
      bus.pcSource    = 2'b00;
      bus.instrDone   = 1'b0;
      bus.illegalOp   = 1'b0;
      bus.state       = 4'd0;
    end
  end

endmodule
